// File: rtl/hybrid_buffer_drain.sv
// Drain controller for per-slot hybrid buffers: pops a requested number of
// features from one slot FIFO and streams them, tagged with the slot's node ID.
module hybrid_buffer_drain #(
    parameter  int NUM_SLOTS     = 16,
    parameter  int READ_WIDTH    = 32,
    parameter  int READ_DEPTH    = 1024,
    parameter  int SLOT_ID_WIDTH = 20,
    localparam int CW            = $clog2(READ_DEPTH),
    localparam int SW            = $clog2(NUM_SLOTS)
) (
    input  logic                               core_clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [SW-1:0]                      req_slot,
    input  logic [CW-1:0]                      req_count,
    output logic [NUM_SLOTS-1:0]               pop,
    input  logic [NUM_SLOTS-1:0]               out_feature_valid,
    input  logic [NUM_SLOTS*READ_WIDTH-1:0]    out_feature,
    input  logic [NUM_SLOTS*SLOT_ID_WIDTH-1:0] slot_node_id,
    output logic                               drain_valid,
    input  logic                               drain_ready,
    output logic [READ_WIDTH-1:0]              drain_data,
    output logic [SLOT_ID_WIDTH-1:0]           drain_node_id,
    output logic                               drain_last,
    output logic                               done_valid,
    output logic [SW-1:0]                      done_slot
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [SW-1:0]            sel_slot_q, sel_slot_d;
    logic [SLOT_ID_WIDTH-1:0] sel_node_id_q, sel_node_id_d;
    logic [CW-1:0]            remaining_q, remaining_d;

    logic                  in_drain;
    logic                  head_valid;
    logic [READ_WIDTH-1:0] head_data;
    logic                  fire;

    // rst gates the combinational outputs so they drop the instant reset asserts
    assign in_drain   = (state_q == DRAIN) && !rst;
    assign head_valid = out_feature_valid[sel_slot_q];
    assign head_data  = out_feature[int'(sel_slot_q)*READ_WIDTH +: READ_WIDTH];

    assign drain_valid   = in_drain && head_valid;
    assign drain_data    = in_drain ? head_data : '0;
    assign drain_last    = drain_valid && (remaining_q == CW'(1));
    assign drain_node_id = sel_node_id_q;
    assign fire          = drain_valid && drain_ready;

    assign req_ready  = (state_q == IDLE) && !rst;
    assign done_valid = (state_q == DONE) && !rst;
    assign done_slot  = sel_slot_q;

    always_comb begin
        pop             = '0;
        pop[sel_slot_q] = fire;
    end

    always_comb begin
        state_d       = state_q;
        sel_slot_d    = sel_slot_q;
        sel_node_id_d = sel_node_id_q;
        remaining_d   = remaining_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    sel_slot_d    = req_slot;
                    sel_node_id_d =
                        slot_node_id[int'(req_slot)*SLOT_ID_WIDTH +: SLOT_ID_WIDTH];
                    remaining_d   = req_count;
                    state_d       = (req_count != '0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (fire) begin
                    remaining_d = remaining_q - CW'(1);
                    if (drain_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            sel_slot_q    <= '0;
            sel_node_id_q <= '0;
            remaining_q   <= '0;
        end else begin
            state_q       <= state_d;
            sel_slot_q    <= sel_slot_d;
            sel_node_id_q <= sel_node_id_d;
            remaining_q   <= remaining_d;
        end
    end

endmodule

// File: tb/tb_hybrid_buffer_drain.sv
// Bench for hybrid_buffer_drain: slot FIFO models, beat/done scoreboards,
// a vector table plus hand-written starve, node-ID and reset sequences.
module tb_hybrid_buffer_drain;

    localparam int NS = 16;
    localparam int RW = 32;
    localparam int RD = 1024;
    localparam int IW = 20;
    localparam int CW = $clog2(RD);
    localparam int SW = $clog2(NS);

    logic             core_clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [SW-1:0]    req_slot;
    logic [CW-1:0]    req_count;
    logic [NS-1:0]    pop;
    logic [NS-1:0]    out_feature_valid;
    logic [NS*RW-1:0] out_feature;
    logic [NS*IW-1:0] slot_node_id;
    logic             drain_valid;
    logic             drain_ready;
    logic [RW-1:0]    drain_data;
    logic [IW-1:0]    drain_node_id;
    logic             drain_last;
    logic             done_valid;
    logic [SW-1:0]    done_slot;

    hybrid_buffer_drain #(
        .NUM_SLOTS    (NS),
        .READ_WIDTH   (RW),
        .READ_DEPTH   (RD),
        .SLOT_ID_WIDTH(IW)
    ) dut (
        .core_clk         (core_clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_slot         (req_slot),
        .req_count        (req_count),
        .pop              (pop),
        .out_feature_valid(out_feature_valid),
        .out_feature      (out_feature),
        .slot_node_id     (slot_node_id),
        .drain_valid      (drain_valid),
        .drain_ready      (drain_ready),
        .drain_data       (drain_data),
        .drain_node_id    (drain_node_id),
        .drain_last       (drain_last),
        .done_valid       (done_valid),
        .done_slot        (done_slot)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        logic [RW-1:0] data;
        logic [IW-1:0] nid;
        logic          last;
    } beat_t;

    typedef struct {
        int slot;
        int count;
        int preload;
        int mode;
    } vec_t;

    beat_t         sb[$];
    int            done_sb[$];
    logic [RW-1:0] fifo[NS][$];
    logic [IW-1:0] nids[NS];

    int   checks = 0;
    int   passed = 0;
    int   exp_sel = 0;
    int   ready_mode = 0;
    int   rcnt = 0;
    int   beats = 0;
    int   dones = 0;
    int   pops_seen = 0;
    int   cyc = 0;
    logic stall_prev = 1'b0;
    logic accepted_now = 1'b0;
    logic [RW-1:0] held_data;
    logic          held_last;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic bad(input string name);
        checks++;
        $display("FAIL %s: event occurred, required none", name);
    endtask

    task automatic refresh();
        for (int s = 0; s < NS; s++) begin
            out_feature_valid[s] = fifo[s].size() != 0;
            out_feature[s*RW +: RW] = (fifo[s].size() != 0) ? fifo[s][0] : '0;
            slot_node_id[s*IW +: IW] = nids[s];
        end
    endtask

    task automatic set_ready();
        case (ready_mode)
            0:       drain_ready = 1'b1;
            1:       drain_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
            default: drain_ready = 1'($urandom_range(0, 1));
        endcase
        rcnt++;
    endtask

    task automatic cycle();
        logic [NS-1:0] psnap;
        logic          fire;
        beat_t         b;
        @(negedge core_clk);
        fire = drain_valid && drain_ready;
        chk("pop", pop, fire ? (NS'(1) << exp_sel) : NS'(0));
        if (drain_valid) chk("head_valid", out_feature_valid[exp_sel], 1);
        if (stall_prev)
            chk("stall_hold", {drain_valid, drain_last, drain_data},
                {1'b1, held_last, held_data});
        if (fire) begin
            if (sb.size() == 0) bad("beat_unexpected");
            else begin
                b = sb.pop_front();
                chk("data", drain_data, b.data);
                chk("node_id", drain_node_id, b.nid);
                chk("last", drain_last, b.last);
            end
            beats++;
        end
        if (done_valid) begin
            if (done_sb.size() == 0) bad("done_unexpected");
            else chk("done_slot", done_slot, done_sb.pop_front());
            dones++;
        end
        accepted_now = req_valid && req_ready;
        stall_prev   = drain_valid && !drain_ready && !rst;
        held_data    = drain_data;
        held_last    = drain_last;
        psnap        = pop;
        @(posedge core_clk);
        #1;
        cyc++;
        if (accepted_now) req_valid = 1'b0;
        for (int s = 0; s < NS; s++)
            if (psnap[s]) void'(fifo[s].pop_front());
        pops_seen += $countones(psnap);
        set_ready();
        refresh();
    endtask

    task automatic push_words(input int slot, input int n, input logic [RW-1:0] base);
        for (int i = 0; i < n; i++) fifo[slot].push_back(base + RW'(i));
        refresh();
    endtask

    task automatic expect_beats(input int count, input logic [RW-1:0] base,
                                input logic [IW-1:0] nid);
        for (int i = 0; i < count; i++)
            sb.push_back('{base + RW'(i), nid, i == count - 1});
    endtask

    task automatic issue_req(input int slot, input int count);
        int n;
        exp_sel   = slot;
        req_slot  = SW'(slot);
        req_count = CW'(count);
        req_valid = 1'b1;
        done_sb.push_back(slot);
        n = 0;
        while (req_valid && n < 20) begin
            cycle();
            n++;
        end
        if (req_valid) begin
            bad("accept_timeout");
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int d0, input int budget, output int lat);
        int c0;
        c0 = cyc;
        while (dones == d0 && cyc - c0 < budget) cycle();
        if (dones == d0) bad("done_timeout");
        lat = cyc - c0;
    endtask

    vec_t vecs[6];

    initial begin
        int lat, d0, p0, b0, n;
        logic [RW-1:0] base;

        vecs[0] = '{3, 4, 4, 0};
        vecs[1] = '{3, 4, 4, 1};
        vecs[2] = '{7, 0, 2, 0};
        vecs[3] = '{10, 5, 5, 2};
        vecs[4] = '{15, 1, 3, 0};
        vecs[5] = '{2, 9, 9, 1};

        rst = 1'b1;
        req_valid = 1'b0;
        req_slot = '0;
        req_count = '0;
        drain_ready = 1'b0;
        for (int s = 0; s < NS; s++) nids[s] = IW'(20'h100 + s);
        refresh();

        repeat (2) @(negedge core_clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_pop", pop, 0);
        chk("rst_drain_valid", drain_valid, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_drain_data", drain_data, 0);
        @(posedge core_clk);
        #1;
        rst = 1'b0;
        @(negedge core_clk);
        chk("idle_req_ready", req_ready, 1);
        chk("idle_node_id", drain_node_id, 0);
        chk("idle_done_slot", done_slot, 0);
        @(posedge core_clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            base = 32'hC0DE_0000 | RW'(v << 8);
            nids[vecs[v].slot] = IW'(20'h1000 + v * 20'h111 + vecs[v].slot);
            push_words(vecs[v].slot, vecs[v].preload, base);
            expect_beats(vecs[v].count, base, nids[vecs[v].slot]);
            ready_mode = vecs[v].mode;
            rcnt = 0;
            set_ready();
            p0 = pops_seen;
            d0 = dones;
            issue_req(vecs[v].slot, vecs[v].count);
            wait_done(d0, 300, lat);
            chk("vec_pops", pops_seen - p0, vecs[v].count);
            chk("vec_left", fifo[vecs[v].slot].size(), vecs[v].preload - vecs[v].count);
            chk("vec_sb_empty", sb.size(), 0);
            if (vecs[v].mode == 0) chk("vec_latency", lat, vecs[v].count + 1);
            chk("vec_req_ready_after", req_ready, 1);
            fifo[vecs[v].slot].delete();
            refresh();
        end

        // starved slot: two words present, three requested
        ready_mode = 0;
        set_ready();
        base = 32'h5A5A_0000;
        push_words(5, 2, base);
        expect_beats(3, base, nids[5]);
        d0 = dones;
        b0 = beats;
        issue_req(5, 3);
        n = 0;
        while (beats < b0 + 2 && n < 20) begin
            cycle();
            n++;
        end
        chk("starve_two_beats", beats - b0, 2);
        repeat (5) cycle();
        chk("starve_no_valid", drain_valid, 0);
        chk("starve_no_done", dones - d0, 0);
        chk("starve_not_ready", req_ready, 0);
        push_words(5, 1, base + 32'd2);
        wait_done(d0, 20, lat);
        chk("starve_sb_empty", sb.size(), 0);
        chk("starve_fifo_empty", fifo[5].size(), 0);

        // node ID changes mid-drain; neighbouring slot 1 holds a valid head
        nids[0] = 20'hAAAAA;
        base = 32'h0BAD_0000;
        push_words(0, 8, base);
        push_words(1, 1, 32'hDEAD_BEEF);
        expect_beats(8, base, 20'hAAAAA);
        d0 = dones;
        b0 = beats;
        issue_req(0, 8);
        n = 0;
        while (dones == d0 && n < 40) begin
            if (beats - b0 == 2) begin
                nids[0] = 20'h55555;
                refresh();
            end
            cycle();
            n++;
        end
        if (dones == d0) bad("nid_done_timeout");
        chk("nid_sb_empty", sb.size(), 0);
        chk("nid_slot1_untouched", fifo[1].size(), 1);
        fifo[1].delete();
        refresh();

        // reset after three of six beats
        base = 32'h7777_0000;
        nids[9] = 20'h00999;
        push_words(9, 6, base);
        expect_beats(6, base, 20'h00999);
        b0 = beats;
        issue_req(9, 6);
        n = 0;
        while (beats < b0 + 3 && n < 20) begin
            cycle();
            n++;
        end
        chk("rst_mid_beats", beats - b0, 3);
        chk("rst_mid_pre_valid", drain_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_pop", pop, 0);
        chk("rst_mid_valid", drain_valid, 0);
        chk("rst_mid_req_ready", req_ready, 0);
        chk("rst_mid_node_id", drain_node_id, 0);
        sb.delete();
        done_sb.delete();
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_mid_idle_ready", req_ready, 1);
        chk("rst_mid_left", fifo[9].size(), 3);
        expect_beats(3, base + 32'd3, 20'h00999);
        d0 = dones;
        issue_req(9, 3);
        wait_done(d0, 20, lat);
        chk("rst_resume_sb_empty", sb.size(), 0);
        chk("rst_resume_fifo_empty", fifo[9].size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
